// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - register-file write-port arbiter with long-latency result FIFO
//
// Purpose: drives the two register-file write ports. The W-stage pipeline
// writeback always gets its port. Out-of-band mul/div results are queued in a
// DEPTH-entry FIFO and drained into the E port on cycles when the pipeline
// leaves it idle. pend_mask lists every register that has a write queued or
// on the output registers, so decode can stall readers and WAW writers.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   W_dstE/W_valE         pipeline E-port write (dst 0 = no write)
//   W_dstM/W_valM         pipeline M-port write (dst 0 = no write)
//   lu_valid/lu_dst/lu_val/lu_ready  long-latency result handshake
//   dstE/valE, dstM/valM  registered register-file write ports
//   pend_mask             pending-write mask, bit 0 always 0
//   err_waw               sticky: pipeline write hit the FIFO head destination
//
// Optional: define WB_DUAL_DRAIN_EN to let an idle M port drain the FIFO too.
module wb_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  W_dstE,
    input  logic [31:0] W_valE,
    input  logic [4:0]  W_dstM,
    input  logic [31:0] W_valM,
    input  logic        lu_valid,
    input  logic [4:0]  lu_dst,
    input  logic [31:0] lu_val,
    output logic        lu_ready,
    output logic [4:0]  dstE,
    output logic [31:0] valE,
    output logic [4:0]  dstM,
    output logic [31:0] valM,
    output logic [31:0] pend_mask,
    output logic        err_waw
);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [4:0]    fifo_dst [DEPTH];
    logic [31:0]   fifo_val [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          e_from_fifo;

    logic          fifo_nonempty;
    logic [4:0]    head_dst;
    logic [31:0]   head_val;
    logic          head_coll;
    logic          push;
    logic          drain_e;
    logic          drain_m;
    logic [1:0]    n_pop;
    logic [4:0]    next_dstE;
    logic [31:0]   next_valE;
    logic [4:0]    next_dstM;
    logic [31:0]   next_valM;
    logic          next_e_fifo;
    logic [31:0]   pend_acc;
    logic [AW-1:0] scan_ptr;

`ifdef WB_DUAL_DRAIN_EN
    logic          m_from_fifo;
    logic          next_m_fifo;
    logic          has_second;
    logic [AW-1:0] second_ptr;
    logic [4:0]    second_dst;
    logic [31:0]   second_val;
    logic          second_coll;

    assign has_second  = (count >= (AW+1)'(2));
    assign second_ptr  = rd_ptr + AW'(1);
    assign second_dst  = fifo_dst[second_ptr];
    assign second_val  = fifo_val[second_ptr];
    assign second_coll = has_second &&
                         (((W_dstE != 5'd0) && (second_dst == W_dstE)) ||
                          ((W_dstM != 5'd0) && (second_dst == W_dstM)));
`endif

    assign lu_ready      = (count < FULL_COUNT);
    assign fifo_nonempty = (count != '0);
    assign head_dst      = fifo_dst[rd_ptr];
    assign head_val      = fifo_val[rd_ptr];
    // The head never holds dst 0 (those are dropped on push), so a plain
    // compare against the nonzero pipeline destinations is enough.
    assign head_coll     = fifo_nonempty &&
                           (((W_dstE != 5'd0) && (head_dst == W_dstE)) ||
                            ((W_dstM != 5'd0) && (head_dst == W_dstM)));
    assign push          = lu_valid && lu_ready && (lu_dst != 5'd0);

    always_comb begin
        next_dstE   = W_dstE;
        next_valE   = W_valE;
        next_dstM   = W_dstM;
        next_valM   = W_valM;
        next_e_fifo = 1'b0;
        drain_e     = 1'b0;
        drain_m     = 1'b0;
        if (W_dstE == 5'd0) begin
            drain_e     = fifo_nonempty && !head_coll;
            next_dstE   = drain_e ? head_dst : 5'd0;
            next_valE   = drain_e ? head_val : 32'd0;
            next_e_fifo = drain_e;
        end
`ifdef WB_DUAL_DRAIN_EN
        next_m_fifo = 1'b0;
        if (W_dstM == 5'd0) begin
            if (W_dstE == 5'd0) begin
                // Second entry only moves if the head moved: order is strict.
                drain_m = drain_e && has_second && !second_coll;
                if (drain_m) begin
                    next_dstM = second_dst;
                    next_valM = second_val;
                end
            end else begin
                drain_m = fifo_nonempty && !head_coll;
                if (drain_m) begin
                    next_dstM = head_dst;
                    next_valM = head_val;
                end
            end
            next_m_fifo = drain_m;
        end
`endif
        n_pop = {1'b0, drain_e} + {1'b0, drain_m};
    end

    always_comb begin
        pend_acc = 32'd0;
        scan_ptr = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            scan_ptr = rd_ptr + AW'(i);
            if ((AW+1)'(i) < count) begin
                pend_acc[fifo_dst[scan_ptr]] = 1'b1;
            end
        end
        if (e_from_fifo) begin
            pend_acc[dstE] = 1'b1;
        end
`ifdef WB_DUAL_DRAIN_EN
        if (m_from_fifo) begin
            pend_acc[dstM] = 1'b1;
        end
`endif
        pend_acc[0] = 1'b0;
    end

    assign pend_mask = pend_acc;

    always_ff @(posedge clock) begin
        if (reset) begin
            dstE        <= 5'd0;
            valE        <= 32'd0;
            dstM        <= 5'd0;
            valM        <= 32'd0;
            e_from_fifo <= 1'b0;
            err_waw     <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            dstE        <= next_dstE;
            valE        <= next_valE;
            dstM        <= next_dstM;
            valM        <= next_valM;
            e_from_fifo <= next_e_fifo;
            if (head_coll) begin
                err_waw <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            // DEPTH is a power of two, so pointer overflow is the wrap.
            rd_ptr <= rd_ptr + AW'(n_pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(n_pop);
        end
    end

`ifdef WB_DUAL_DRAIN_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            m_from_fifo <= 1'b0;
        end else begin
            m_from_fifo <= next_m_fifo;
        end
    end
`endif

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_dst[wr_ptr] <= lu_dst;
            fifo_val[wr_ptr] <= lu_val;
        end
    end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb/tb_wb_write_arbiter.sv - randomized scoreboard bench for wb_write_arbiter
module tb_wb_write_arbiter;
    localparam int DEPTH    = 4;
    localparam int AW       = 2;
    localparam int N_CYCLES = 4000;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  W_dstE;
    logic [31:0] W_valE;
    logic [4:0]  W_dstM;
    logic [31:0] W_valM;
    logic        lu_valid;
    logic [4:0]  lu_dst;
    logic [31:0] lu_val;
    logic        lu_ready;
    logic [4:0]  dstE;
    logic [31:0] valE;
    logic [4:0]  dstM;
    logic [31:0] valM;
    logic [31:0] pend_mask;
    logic        err_waw;

    always #5 clock = ~clock;

    wb_write_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock(clock), .reset(reset),
        .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
        .lu_valid(lu_valid), .lu_dst(lu_dst), .lu_val(lu_val), .lu_ready(lu_ready),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .pend_mask(pend_mask), .err_waw(err_waw)
    );

    typedef struct packed {
        logic [4:0]  dstE;
        logic [31:0] valE;
        logic [4:0]  dstM;
        logic [31:0] valM;
        logic        lu_ready;
        logic        err_waw;
        logic [31:0] pend_mask;
    } exp_t;

    typedef struct {
        logic [4:0]  dst;
        logic [31:0] val;
    } ent_t;

    exp_t exp_q[$];
    ent_t model_q[$];
    logic model_err = 1'b0;
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;

    function automatic bit hits(input logic [4:0] d, input logic [4:0] we, input logic [4:0] wm);
        return ((we != 5'd0) && (d == we)) || ((wm != 5'd0) && (d == wm));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
        end
    endtask

    // Reference: the FIFO is a plain queue; each cycle works out what the
    // register file should see after the coming edge.
    task automatic model_step();
        exp_t e;
        ent_t ent;
        int   popped;
        bit   ready;
        bit   ef;
        bit   mf;
        e = '0;
        if (reset) begin
            model_q.delete();
            model_err  = 1'b0;
            e.lu_ready = 1'b1;
            exp_q.push_back(e);
            return;
        end
        ready  = (model_q.size() < DEPTH);
        popped = 0;
        ef     = 1'b0;
        mf     = 1'b0;
        e.dstE = W_dstE;
        e.valE = W_valE;
        e.dstM = W_dstM;
        e.valM = W_valM;
        if (model_q.size() > 0 && hits(model_q[0].dst, W_dstE, W_dstM)) model_err = 1'b1;
        if (W_dstE == 5'd0) begin
            if (model_q.size() > 0 && !hits(model_q[0].dst, W_dstE, W_dstM)) begin
                e.dstE = model_q[0].dst;
                e.valE = model_q[0].val;
                popped = 1;
                ef     = 1'b1;
            end else begin
                e.dstE = 5'd0;
                e.valE = 32'd0;
            end
        end
`ifdef WB_DUAL_DRAIN_EN
        if (W_dstM == 5'd0) begin
            if (W_dstE == 5'd0) begin
                if (popped == 1 && model_q.size() >= 2 && !hits(model_q[1].dst, W_dstE, W_dstM)) begin
                    e.dstM = model_q[1].dst;
                    e.valM = model_q[1].val;
                    popped = 2;
                    mf     = 1'b1;
                end
            end else if (model_q.size() > 0 && !hits(model_q[0].dst, W_dstE, W_dstM)) begin
                e.dstM = model_q[0].dst;
                e.valM = model_q[0].val;
                popped = 1;
                mf     = 1'b1;
            end
        end
`endif
        repeat (popped) void'(model_q.pop_front());
        if (lu_valid && ready && lu_dst != 5'd0) begin
            ent.dst = lu_dst;
            ent.val = lu_val;
            model_q.push_back(ent);
        end
        e.lu_ready = (model_q.size() < DEPTH);
        e.err_waw  = model_err;
        foreach (model_q[i]) e.pend_mask[model_q[i].dst] = 1'b1;
        if (ef) e.pend_mask[e.dstE] = 1'b1;
        if (mf) e.pend_mask[e.dstM] = 1'b1;
        e.pend_mask[0] = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic drive(input int c);
        int phase;
        int busy_pct;
        int m_pct;
        int lu_pct;
        phase = (c / 120) % 4;
        case (phase)
            0: begin busy_pct = 90; m_pct = 50; lu_pct = 60; end
            1: begin busy_pct = 5;  m_pct = 20; lu_pct = 30; end
            2: begin busy_pct = 50; m_pct = 50; lu_pct = 60; end
            default: begin busy_pct = 20; m_pct = 60; lu_pct = 70; end
        endcase
        reset    = (c < 2) || ($urandom_range(0, 299) == 0);
        W_dstE   = ($urandom_range(0, 99) < busy_pct) ? 5'($urandom_range(1, 9)) : 5'd0;
        W_valE   = $urandom;
        W_dstM   = ($urandom_range(0, 99) < m_pct) ? 5'($urandom_range(1, 9)) : 5'd0;
        W_valM   = $urandom;
        lu_valid = (c >= 2) && ($urandom_range(0, 99) < lu_pct);
        lu_dst   = 5'($urandom_range(0, 9));
        lu_val   = $urandom;
    endtask

    initial begin
        reset    = 1'b1;
        W_dstE   = 5'd0;
        W_valE   = 32'd0;
        W_dstM   = 5'd0;
        W_valM   = 32'd0;
        lu_valid = 1'b0;
        lu_dst   = 5'd0;
        lu_val   = 32'd0;
        for (int c = 0; c < N_CYCLES; c++) begin
            @(negedge clock);
            drive(c);
            model_step();
        end
        @(negedge clock);
        reset    = 1'b0;
        W_dstE   = 5'd0;
        W_dstM   = 5'd0;
        lu_valid = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("dstE", 32'(dstE), 32'(e.dstE));
                check("valE", valE, e.valE);
                check("dstM", 32'(dstM), 32'(e.dstM));
                check("valM", valM, e.valM);
                check("lu_ready", 32'(lu_ready), 32'(e.lu_ready));
                check("err_waw", 32'(err_waw), 32'(e.err_waw));
                check("pend_mask", pend_mask, e.pend_mask);
            end
        end
    end

    initial begin
        #(N_CYCLES * 20 + 2000);
        failures++;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
